// File: rtl/noc_pkg.sv
// Shared constants for the NoC node adapter: flit layout defaults and the idle flit.
package noc_pkg;

   localparam int FLIT_W_DEF  = 17;
   localparam int N_NODES_DEF = 16;

   // Index of the valid flag in a flit of width w (always the MSB).
   function automatic int valid_idx(input int w);
      return w - 1;
   endfunction

   localparam int                    VALID_BIT = valid_idx(FLIT_W_DEF);
   localparam logic [FLIT_W_DEF-1:0] IDLE_FLIT = '0;

endpackage

// File: rtl/noc_port_fifo.sv
// Parametrised synchronous FIFO with occupancy count; head is visible on dout.
module noc_port_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO is legal only when the same edge frees a slot.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array: written on push only.
   // NOTE: the data array is deliberately not reset; the count and pointers define validity, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally modulo DEPTH (power of 2); count tracks occupancy.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/noc_node_adapter.sv
// Per-node injection/ejection buffering between clients and router local ports.
module noc_node_adapter
   import noc_pkg::*;
#(
   parameter int N_NODES = N_NODES_DEF,
   parameter int FLIT_W  = FLIT_W_DEF,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_NODES*FLIT_W-1:0]  inj_data,
   input  logic [N_NODES-1:0]         inj_valid,
   output logic [N_NODES-1:0]         inj_ready,
   output logic [N_NODES*FLIT_W-1:0]  data_i,
   input  logic [N_NODES-1:0]         local_full,
   input  logic [N_NODES*FLIT_W-1:0]  data_o,
   output logic [N_NODES*FLIT_W-1:0]  ej_data,
   output logic [N_NODES-1:0]         ej_valid,
   input  logic [N_NODES-1:0]         ej_ready,
   output logic [N_NODES*CNT_W-1:0]   drop_cnt
);

   localparam int                CW    = $clog2(DEPTH) + 1;
   localparam int                VB    = valid_idx(FLIT_W);
   localparam logic [FLIT_W-1:0] VMASK = {1'b1, {(FLIT_W-1){1'b0}}};

   logic run_q;

   // Holds inj_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run_q <= 1'b0;
      else      run_q <= 1'b1;
   end

   for (genvar n = 0; n < N_NODES; n++) begin : g_node
      logic [FLIT_W-1:0] inj_head;
      logic [FLIT_W-1:0] ej_head;
      logic [FLIT_W-1:0] data_i_q;
      logic [CW-1:0]     inj_cnt;
      logic [CW-1:0]     ej_cnt;
      logic [CNT_W-1:0]  drop_q;
      logic              inj_push;
      logic              inj_pop;
      logic              ej_in_valid;
      logic              ej_full;
      logic              ej_pop;
      logic              ej_push;
      logic              ej_drop;

      assign inj_ready[n] = run_q && (inj_cnt < CW'(DEPTH));
      assign inj_push     = inj_valid[n] && inj_ready[n];
      assign inj_pop      = (inj_cnt != '0) && !local_full[n];

      assign ej_in_valid  = data_o[n*FLIT_W + VB];
      assign ej_full      = (ej_cnt == CW'(DEPTH));
      assign ej_pop       = ej_valid[n] && ej_ready[n];
      assign ej_push      = ej_in_valid && (!ej_full || ej_pop);
      assign ej_drop      = ej_in_valid && ej_full && !ej_pop;

      noc_port_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_inj_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (inj_push),
         .pop   (inj_pop),
         .din   (inj_data[n*FLIT_W +: FLIT_W]),
         .dout  (inj_head),
         .count (inj_cnt)
      );

      noc_port_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_ej_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (ej_push),
         .pop   (ej_pop),
         .din   (data_o[n*FLIT_W +: FLIT_W]),
         .dout  (ej_head),
         .count (ej_cnt)
      );

      // Router-facing output register: popped head with valid forced, else idle.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)         data_i_q <= FLIT_W'(IDLE_FLIT);
         else if (inj_pop) data_i_q <= inj_head | VMASK;
         else              data_i_q <= FLIT_W'(IDLE_FLIT);
      end

      // Saturating count of ejection flits lost to a full, non-draining FIFO.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                          drop_q <= '0;
         else if (ej_drop && drop_q != '1)  drop_q <= drop_q + CNT_W'(1);
      end

      assign data_i[n*FLIT_W +: FLIT_W]  = data_i_q;
      assign ej_valid[n]                 = (ej_cnt != '0);
      assign ej_data[n*FLIT_W +: FLIT_W] = ej_head;
      assign drop_cnt[n*CNT_W +: CNT_W]  = drop_q;
   end

endmodule

// File: tb/tb_noc_node_adapter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_noc_node_adapter;

   localparam int N  = 16;
   localparam int W  = 17;
   localparam int D  = 4;
   localparam int CW = 16;
   localparam logic [W-1:0] VMASK = 17'h10000;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N*W-1:0]   inj_data   = '0;
   logic [N-1:0]     inj_valid  = '0;
   logic [N-1:0]     inj_ready;
   logic [N*W-1:0]   data_i;
   logic [N-1:0]     local_full = '0;
   logic [N*W-1:0]   data_o     = '0;
   logic [N*W-1:0]   ej_data;
   logic [N-1:0]     ej_valid;
   logic [N-1:0]     ej_ready   = '0;
   logic [N*CW-1:0]  drop_cnt;

   // Second instance with a 2-bit drop counter for saturation.
   logic [2*W-1:0]   inj_data2   = '0;
   logic [1:0]       inj_valid2  = '0;
   logic [1:0]       inj_ready2;
   logic [2*W-1:0]   data_i2;
   logic [1:0]       local_full2 = '0;
   logic [2*W-1:0]   data_o2     = '0;
   logic [2*W-1:0]   ej_data2;
   logic [1:0]       ej_valid2;
   logic [1:0]       ej_ready2   = '0;
   logic [3:0]       drop_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   noc_node_adapter #(.N_NODES(N), .FLIT_W(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
      .data_i(data_i), .local_full(local_full), .data_o(data_o), .ej_data(ej_data),
      .ej_valid(ej_valid), .ej_ready(ej_ready), .drop_cnt(drop_cnt)
   );

   noc_node_adapter #(.N_NODES(2), .FLIT_W(W), .DEPTH(D), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .inj_data(inj_data2), .inj_valid(inj_valid2), .inj_ready(inj_ready2),
      .data_i(data_i2), .local_full(local_full2), .data_o(data_o2), .ej_data(ej_data2),
      .ej_valid(ej_valid2), .ej_ready(ej_ready2), .drop_cnt(drop_cnt2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (main instance) ----------------
   logic [W-1:0] m_inj [N][$];
   logic [W-1:0] m_ej  [N][$];
   logic [W-1:0] m_di  [N];
   int           m_drop [N];
   bit           m_run;
   bit           rdy, epop, was_full;
   bit           cmp_en = 1'b0;

   task automatic model_clear();
      for (int n = 0; n < N; n++) begin
         m_inj[n].delete();
         m_ej[n].delete();
         m_di[n]   = '0;
         m_drop[n] = 0;
      end
      m_run = 1'b0;
   endtask

   always @(negedge rst) model_clear();

   always @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N; n++) begin
            rdy = m_run && (m_inj[n].size() < D);
            if (m_inj[n].size() > 0 && !local_full[n]) m_di[n] = m_inj[n].pop_front() | VMASK;
            else                                       m_di[n] = '0;
            if (inj_valid[n] && rdy) m_inj[n].push_back(inj_data[n*W +: W]);
            was_full = (m_ej[n].size() >= D);
            epop     = (m_ej[n].size() > 0) && ej_ready[n];
            if (epop) void'(m_ej[n].pop_front());
            if (data_o[n*W + W-1]) begin
               if (!was_full || epop)    m_ej[n].push_back(data_o[n*W +: W]);
               else if (m_drop[n] < 65535) m_drop[n]++;
            end
         end
         m_run = 1'b1;
      end
   end

   // Per-cycle comparison of every node's outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int n = 0; n < N; n++) begin
            check($sformatf("data_i[%0d]", n), 32'(data_i[n*W +: W]), 32'(m_di[n]));
            check($sformatf("inj_ready[%0d]", n), 32'(inj_ready[n]),
                  32'(m_run && (m_inj[n].size() < D)));
            check($sformatf("ej_valid[%0d]", n), 32'(ej_valid[n]), 32'(m_ej[n].size() > 0));
            if (m_ej[n].size() > 0)
               check($sformatf("ej_data[%0d]", n), 32'(ej_data[n*W +: W]), 32'(m_ej[n][0]));
            check($sformatf("drop_cnt[%0d]", n), 32'(drop_cnt[n*CW +: CW]), 32'(m_drop[n]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      model_clear();
      cmp_en = 1'b1;
      cyc();
      cyc();
      check("reset inj_ready", 32'(inj_ready), 32'h0);
      check("reset data_i", 32'(|data_i), 32'h0);
      check("reset ej_valid", 32'(ej_valid), 32'h0);
      rst = 1'b1;
      cyc();
      check("inj_ready after release", 32'(inj_ready), 32'hFFFF);

      // Node 3 single flit: visible one cycle after acceptance, then idle.
      inj_data[3*W +: W] = 17'h00005;
      inj_valid[3] = 1'b1;
      cyc();
      inj_valid[3] = 1'b0;
      check("n3 idle at accept", 32'(data_i[3*W +: W]), 32'h0);
      cyc();
      check("n3 flit out", 32'(data_i[3*W +: W]), 32'h10005);
      cyc();
      check("n3 idle after", 32'(data_i[3*W +: W]), 32'h0);

      // Node 7 backpressured: 4 of 6 accepted, then drained in order.
      local_full[7] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         inj_data[7*W +: W] = W'(17'h00100 + i);
         inj_valid[7] = 1'b1;
         cyc();
      end
      inj_valid[7] = 1'b0;
      check("n7 inj_ready full", 32'(inj_ready[7]), 32'h0);
      check("n7 idle while full", 32'(data_i[7*W +: W]), 32'h0);
      local_full[7] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("n7 drain %0d", i), 32'(data_i[7*W +: W]), 32'h10100 + 32'(i));
      end
      cyc();
      check("n7 idle after drain", 32'(data_i[7*W +: W]), 32'h0);

      // Node 0 ejection overflow: 6 flits, 4 kept, 2 dropped.
      ej_ready[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data_o[0 +: W] = W'(17'h10A00 + i);
         cyc();
      end
      data_o[0 +: W] = '0;
      check("n0 ej_valid", 32'(ej_valid[0]), 32'h1);
      check("n0 ej head", 32'(ej_data[0 +: W]), 32'h10A00);
      check("n0 drop 2", 32'(drop_cnt[0 +: CW]), 32'd2);
      cyc();
      check("n0 head stable", 32'(ej_data[0 +: W]), 32'h10A00);

      // Full FIFO with simultaneous pop accepts the new flit.
      ej_ready[0] = 1'b1;
      data_o[0 +: W] = 17'h10B00;
      cyc();
      data_o[0 +: W] = '0;
      check("n0 no drop on pop", 32'(drop_cnt[0 +: CW]), 32'd2);
      begin
         logic [W-1:0] exp_seq [4];
         exp_seq[0] = 17'h10A01; exp_seq[1] = 17'h10A02;
         exp_seq[2] = 17'h10A03; exp_seq[3] = 17'h10B00;
         for (int i = 0; i < 4; i++) begin
            check($sformatf("n0 order %0d", i), 32'(ej_data[0 +: W]), 32'(exp_seq[i]));
            cyc();
         end
      end
      check("n0 drained", 32'(ej_valid[0]), 32'h0);
      ej_ready[0] = 1'b0;

      // 2-bit counter saturates: 4 stored, 5 dropped.
      for (int i = 0; i < 9; i++) begin
         data_o2[0 +: W] = W'(17'h10C00 + i);
         cyc();
      end
      data_o2[0 +: W] = '0;
      check("cnt2 saturated", 32'(drop_cnt2[1:0]), 32'd3);
      check("cnt2 other node", 32'(drop_cnt2[3:2]), 32'd0);
      check("dut2 ej_valid", 32'(ej_valid2), 32'h1);
      check("dut2 ej head", 32'(ej_data2[0 +: W]), 32'h10C00);
      check("dut2 inj_ready", 32'(inj_ready2), 32'h3);
      check("dut2 data_i idle", 32'(|data_i2), 32'h0);

      // Mixed traffic on all nodes, checked by the model each cycle.
      for (int c = 0; c < 60; c++) begin
         for (int n = 0; n < N; n++) begin
            inj_data[n*W +: W] = W'($urandom);
            data_o[n*W +: W]   = W'($urandom);
         end
         inj_valid  = N'($urandom);
         local_full = N'($urandom) & N'($urandom);
         ej_ready   = N'($urandom);
         cyc();
      end

      // Fill buffers on every node, then reset mid-traffic.
      local_full = '1;
      ej_ready   = '0;
      inj_valid  = '1;
      for (int c = 0; c < 5; c++) begin
         for (int n = 0; n < N; n++) begin
            inj_data[n*W +: W] = W'(n * 16 + c);
            data_o[n*W +: W]   = VMASK | W'(n * 16 + c);
         end
         cyc();
      end
      rst = 1'b0;
      #1;
      check("mid rst data_i", 32'(|data_i), 32'h0);
      check("mid rst ej_valid", 32'(ej_valid), 32'h0);
      check("mid rst inj_ready", 32'(inj_ready), 32'h0);
      check("mid rst drop_cnt", 32'(|drop_cnt), 32'h0);
      inj_valid  = '0;
      data_o     = '0;
      local_full = '0;
      ej_ready   = '1;
      cyc();
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cyc();
         check($sformatf("post rst data_i %0d", c), 32'(|data_i), 32'h0);
         check($sformatf("post rst ej_valid %0d", c), 32'(ej_valid), 32'h0);
      end
      check("post rst inj_ready", 32'(inj_ready), 32'hFFFF);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_node_adapter.md
NOC_NODE_ADAPTER -- requirements
Module: noc_node_adapter

Interface
REQ-001 SHALL have parameter N_NODES, default 16, the number of router local ports served.
REQ-002 SHALL have parameter FLIT_W, default 17, the flit width; bit FLIT_W-1 is the valid flag.
REQ-003 SHALL have parameter DEPTH, default 4, the entries per injection and per ejection FIFO; a power of 2, 2..64.
REQ-004 SHALL have parameter CNT_W, default 16, the width of each per-node drop counter.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port inj_data  in  N_NODES*FLIT_W  per-node client flits; node n occupies slice n.
REQ-008 SHALL have port inj_valid  in  N_NODES  per-node client offer.
REQ-009 SHALL have port inj_ready  out  N_NODES  per-node injection FIFO can accept.
REQ-010 SHALL have port data_i  out  N_NODES*FLIT_W  flits driven into the router local inputs.
REQ-011 SHALL have port local_full  in  N_NODES  router local input full, per node.
REQ-012 SHALL have port data_o  in  N_NODES*FLIT_W  flits ejected by the router, per node.
REQ-013 SHALL have port ej_data  out  N_NODES*FLIT_W  ejection FIFO head, per node.
REQ-014 SHALL have port ej_valid  out  N_NODES  ejection FIFO non-empty.
REQ-015 SHALL have port ej_ready  in  N_NODES  client consumes the ejection head.
REQ-016 SHALL have port drop_cnt  out  N_NODES*CNT_W  saturating count of flits lost on ejection overflow.

Function
REQ-017 Nodes SHALL operate fully independently; no signal of node n SHALL affect node m.
REQ-018 inj_ready[n] SHALL be 1 when the injection FIFO count is less than DEPTH, independent of a same-cycle pop; there is no full-FIFO bypass.
REQ-019 On a rising edge with inj_valid[n] and inj_ready[n] both 1, the flit SHALL be written to the injection FIFO.
REQ-020 On each rising edge, if the injection FIFO is non-empty and local_full[n] is 0, the head SHALL be popped and registered onto data_i slice n with bit FLIT_W-1 forced to 1; otherwise the slice SHALL be all-zero (idle).
REQ-021 The minimum latency SHALL be a flit accepted at edge t appearing on data_i after edge t+1; throughput SHALL be 1 flit/cycle/node.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 On each rising edge where bit FLIT_W-1 of data_o slice n is 1, the flit SHALL be pushed into the ejection FIFO; flits with the valid bit clear SHALL be ignored.
REQ-024 An ejection flit SHALL be pushed even when the FIFO is full, provided the same edge pops (ej_valid & ej_ready).
REQ-025 Otherwise, an ejection flit arriving at a full FIFO SHALL be discarded, and drop_cnt[n] SHALL increment, saturating at 2^CNT_W-1.
REQ-026 ej_valid[n] SHALL be 1 when the ejection FIFO is non-empty, and ej_data slice n SHALL equal the head; the head SHALL be popped on an edge with ej_valid & ej_ready.
REQ-027 ej_data SHALL be held stable while ej_valid=1 and ej_ready=0.

Reset
REQ-028 While rst=0, all FIFOs SHALL be emptied, data_i SHALL be all-zero, ej_valid SHALL be 0, inj_ready SHALL be 0, and drop_cnt SHALL be 0, all asynchronously.
REQ-029 inj_ready SHALL rise on the first rising edge after rst deasserts.
REQ-030 Reset asserted mid-traffic SHALL discard all buffered flits without emitting partial or stale flits.

Structure
REQ-031 Package noc_pkg SHALL hold the FLIT_W default, the valid-bit index, the idle-flit constant, and the node-count default.
REQ-032 Sub-module noc_port_fifo SHALL be a parametrised (width, depth) synchronous FIFO with count, instantiated twice per node via generate.

Verification
REQ-033 Reset, then node 3 injects 0x0_0005 with local_full=0 -> data_i[3]=0x1_0005 one cycle after acceptance, then idle 0x0_0000.
REQ-034 local_full[7]=1 held while 6 flits are offered -> 4 accepted, inj_ready[7]=0, data_i[7] idle; local_full drops -> 4 flits emitted in order on consecutive cycles.
REQ-035 ej_ready[0]=0, then 6 valid flits arrive on data_o[0] -> ej_valid=1, head is the first flit, drop_cnt[0]=2.
REQ-036 Ejection FIFO full with ej_ready=1 while a valid flit arrives -> no drop, drop_cnt unchanged, order preserved.
REQ-037 CNT_W=2 with 5 overflow flits -> drop_cnt=3 (saturated).
REQ-038 rst pulsed low with flits buffered on all 16 nodes -> data_i all zero, ej_valid=0, inj_ready=0 immediately; no buffered flit appears after release.
